pwm_phase_scheduler: RTL and testbench

- Queues software phase-offset commands for the PWM generator channels.
- Applies each command group atomically on a PWM period boundary so that no channel sees a mid-period glitch.
- Sits between the AXI register block and the per-channel phase inputs of the PWM generator; it is driven by the generator's period-wrap strobe.

---
 rtl/pwm_phase_scheduler_if.sv | 16 +
 rtl/pwm_phase_scheduler.sv | 177 +++++++++++++++++
 tb/tb_pwm_phase_scheduler.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_phase_scheduler_if.sv
// rtl/pwm_phase_scheduler_if.sv - phase command handshake between register block and scheduler
interface pwm_phase_scheduler_if #(
   parameter int PWM_CNT       = 4,
   parameter int PWM_CNT_WIDTH = 12
);
   localparam int CH_W = (PWM_CNT > 1) ? $clog2(PWM_CNT) : 1;

   logic                     cmd_valid;
   logic                     cmd_ready;
   logic [CH_W-1:0]          cmd_ch;
   logic [PWM_CNT_WIDTH-1:0] cmd_phase;
   logic                     cmd_last;

   modport master (output cmd_valid, cmd_ch, cmd_phase, cmd_last, input cmd_ready);
   modport slave  (input cmd_valid, cmd_ch, cmd_phase, cmd_last, output cmd_ready);
endinterface

// File: rtl/pwm_phase_scheduler.sv
// rtl/pwm_phase_scheduler.sv - queues phase commands and commits each group on a PWM period wrap
// Optional post-commit holdoff in period strobes is built with PWM_SCHED_HOLDOFF_EN.
module pwm_phase_scheduler #(
   parameter int PWM_CNT       = 4,
   parameter int PWM_CNT_WIDTH = 12,
   parameter int FIFO_DEPTH    = 8
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               enable_i,
   input  logic [PWM_CNT_WIDTH-1:0]           period_i,
   input  logic                               period_strobe_i,
   pwm_phase_scheduler_if.slave               cmd_if,
   output logic [PWM_CNT*PWM_CNT_WIDTH-1:0]   phase_out_o,
   output logic [PWM_CNT-1:0]                 phase_upd_o,
   output logic                               busy_o,
   output logic [$clog2(FIFO_DEPTH):0]        groups_pending_o,
   output logic                               err_overflow_o,
   output logic                               err_late_o,
`ifdef PWM_SCHED_HOLDOFF_EN
   input  logic [7:0]                         holdoff_i,
`endif
   input  logic                               clr_err_i
);
   localparam int W    = PWM_CNT_WIDTH;
   localparam int CH_W = (PWM_CNT > 1) ? $clog2(PWM_CNT) : 1;
   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam int CW   = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_APPLY,
`ifdef PWM_SCHED_HOLDOFF_EN
      S_HOLD,
`endif
      S_COMMIT
   } state_t;

   state_t state_q, state_d;

   logic [CH_W-1:0] fifo_ch_q    [FIFO_DEPTH];
   logic [W-1:0]    fifo_phase_q [FIFO_DEPTH];
   logic            fifo_last_q  [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]   level_q, groups_q;

   logic [W-1:0]       shadow_q [PWM_CNT];
   logic [W-1:0]       phase_q  [PWM_CNT];
   logic [PWM_CNT-1:0] touched_q, upd_q;
   logic               err_ovf_q, err_late_q;

   logic            ready, push, pop, commit, late_strobe, head_last;
   logic [CH_W-1:0] head_ch;
   logic [W-1:0]    head_phase, clamped;

`ifdef PWM_SCHED_HOLDOFF_EN
   logic [7:0] hold_cnt_q;
`endif

   assign ready            = (level_q != DEPTH_C);
   assign cmd_if.cmd_ready = ready;
   assign push             = cmd_if.cmd_valid && ready;
   assign pop              = (state_q == S_APPLY) && (level_q != '0);
   assign commit           = (state_q == S_COMMIT);
   assign late_strobe      = period_strobe_i && ((state_q == S_APPLY) || (state_q == S_COMMIT));

   assign head_ch    = fifo_ch_q[rd_ptr_q];
   assign head_phase = fifo_phase_q[rd_ptr_q];
   assign head_last  = fifo_last_q[rd_ptr_q];
   // A phase equal to or beyond the period would never match the counter, so pin it to the last tick.
   assign clamped    = (head_phase >= period_i) ? (period_i - W'(1)) : head_phase;

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (enable_i && (groups_q != '0)) state_d = S_WAIT;
         S_WAIT: begin
            if (!enable_i)            state_d = S_IDLE;
            else if (period_strobe_i) state_d = S_APPLY;
         end
         S_APPLY: if (pop && head_last) state_d = S_COMMIT;
`ifdef PWM_SCHED_HOLDOFF_EN
         S_COMMIT: state_d = (holdoff_i != 8'd0) ? S_HOLD : S_IDLE;
         S_HOLD:   if (period_strobe_i && (hold_cnt_q <= 8'd1)) state_d = S_IDLE;
`else
         S_COMMIT: state_d = S_IDLE;
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_ch_q[wr_ptr_q]    <= cmd_if.cmd_ch;
         fifo_phase_q[wr_ptr_q] <= cmd_if.cmd_phase;
         fifo_last_q[wr_ptr_q]  <= cmd_if.cmd_last;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         groups_q   <= '0;
         err_ovf_q  <= 1'b0;
         err_late_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         level_q <= level_q + CW'(push) - CW'(pop);
         case ({push && cmd_if.cmd_last, commit})
            2'b10:   groups_q <= groups_q + CW'(1);
            2'b01:   groups_q <= groups_q - CW'(1);
            default: groups_q <= groups_q;
         endcase
         if (clr_err_i) begin
            err_ovf_q  <= 1'b0;
            err_late_q <= 1'b0;
         end else begin
            if (cmd_if.cmd_valid && !ready) err_ovf_q  <= 1'b1;
            if (late_strobe)                err_late_q <= 1'b1;
         end
      end
   end

   // Shadow copies absorb a whole group; the visible phases only move together at commit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         touched_q <= '0;
         upd_q     <= '0;
         for (int i = 0; i < PWM_CNT; i++) begin
            shadow_q[i] <= '0;
            phase_q[i]  <= '0;
         end
      end else begin
         upd_q <= '0;
         if (pop) begin
            shadow_q[head_ch]  <= clamped;
            touched_q[head_ch] <= 1'b1;
         end
         if (commit) begin
            for (int i = 0; i < PWM_CNT; i++) begin
               if (touched_q[i]) phase_q[i] <= shadow_q[i];
            end
            upd_q     <= touched_q;
            touched_q <= '0;
         end
      end
   end

`ifdef PWM_SCHED_HOLDOFF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_cnt_q <= 8'd0;
      end else if (commit) begin
         hold_cnt_q <= holdoff_i;
      end else if ((state_q == S_HOLD) && period_strobe_i && (hold_cnt_q != 8'd0)) begin
         hold_cnt_q <= hold_cnt_q - 8'd1;
      end
   end
`endif

   for (genvar g = 0; g < PWM_CNT; g++) begin : g_phase
      assign phase_out_o[g*W +: W] = phase_q[g];
   end

   assign phase_upd_o      = upd_q;
   assign busy_o           = (state_q != S_IDLE);
   assign groups_pending_o = groups_q;
   assign err_overflow_o   = err_ovf_q;
   assign err_late_o       = err_late_q;
endmodule

// File: tb/tb_pwm_phase_scheduler.sv
// tb/tb_pwm_phase_scheduler.sv - scoreboard bench for pwm_phase_scheduler
module tb_pwm_phase_scheduler;
   localparam int N = 4;
   localparam int W = 12;
   localparam int D = 8;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           enable = 1'b0;
   logic           strobe = 1'b0;
   logic           clr_err = 1'b0;
   logic [W-1:0]   period = 12'd1250;
   logic [N*W-1:0] phase_out;
   logic [N-1:0]   phase_upd;
   logic           busy;
   logic [3:0]     groups;
   logic           err_ovf, err_late;
`ifdef PWM_SCHED_HOLDOFF_EN
   logic [7:0]     holdoff = 8'd0;
`endif

   pwm_phase_scheduler_if #(.PWM_CNT(N), .PWM_CNT_WIDTH(W)) cmd_if ();

   pwm_phase_scheduler #(.PWM_CNT(N), .PWM_CNT_WIDTH(W), .FIFO_DEPTH(D)) dut (
      .clk              (clk),
      .rst              (rst),
      .enable_i         (enable),
      .period_i         (period),
      .period_strobe_i  (strobe),
      .cmd_if           (cmd_if),
      .phase_out_o      (phase_out),
      .phase_upd_o      (phase_upd),
      .busy_o           (busy),
      .groups_pending_o (groups),
      .err_overflow_o   (err_ovf),
      .err_late_o       (err_late),
`ifdef PWM_SCHED_HOLDOFF_EN
      .holdoff_i        (holdoff),
`endif
      .clr_err_i        (clr_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [N-1:0]   mask;
      logic [N*W-1:0] ph;
      int             cyc;
   } exp_t;

   exp_t           exp_q[$];
   int             total = 0;
   int             passed = 0;
   logic [N*W-1:0] cur = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst && (phase_upd != '0)) begin
         if (exp_q.size() == 0) begin
            total++;
            $display("FAIL unexpected_commit: got phase_upd=%b phase_out=%h, expected no commit", phase_upd, phase_out);
         end else begin
            e = exp_q.pop_front();
            chk("upd_mask", 64'(phase_upd), 64'(e.mask));
            chk("phase_out", 64'(phase_out), 64'(e.ph));
            chk("commit_cycle", 64'(cyc), 64'(e.cyc));
         end
      end
   end

   task automatic push(input int ch, input int ph, input bit last);
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_ch    = 2'(ch);
      cmd_if.cmd_phase = 12'(ph);
      cmd_if.cmd_last  = last;
      @(negedge clk);
      cmd_if.cmd_valid = 1'b0;
      cmd_if.cmd_last  = 1'b0;
   endtask

   task automatic pulse();
      strobe = 1'b1;
      @(negedge clk);
      strobe = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Commit lands on edge n+1 after the edge that samples the strobe.
   task automatic strobe_expect(input logic [N-1:0] mask, input int n);
      exp_t e;
      e.mask = mask;
      e.ph   = cur;
      e.cyc  = cyc + n + 2;
      exp_q.push_back(e);
      pulse();
   endtask

   task automatic drain(input string name);
      int k = 0;
      while (exp_q.size() != 0 && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk(name, 64'(exp_q.size()), 64'd0);
      exp_q.delete();
   endtask

   function automatic void setph(input int ch, input int v);
      cur[ch*W +: W] = 12'(v);
   endfunction

   initial begin
      #100000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1);
   end

   initial begin
      cmd_if.cmd_valid = 1'b0;
      cmd_if.cmd_ch    = '0;
      cmd_if.cmd_phase = '0;
      cmd_if.cmd_last  = 1'b0;
      idle(2);
      chk("rst_phase_out", 64'(phase_out), 64'd0);
      chk("rst_phase_upd", 64'(phase_upd), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_groups", 64'(groups), 64'd0);
      chk("rst_err_ovf", 64'(err_ovf), 64'd0);
      chk("rst_err_late", 64'(err_late), 64'd0);
      chk("rst_ready", 64'(cmd_if.cmd_ready), 64'd1);
      rst = 1'b0;
      enable = 1'b1;
      idle(1);

      period = 12'd1250;
      push(1, 625, 1);
      chk("t1_groups_1", 64'(groups), 64'd1);
      idle(1);
      chk("t1_busy_wait", 64'(busy), 64'd1);
      setph(1, 625);
      strobe_expect(4'b0010, 1);
      drain("t1_drain");
      chk("t1_groups_0", 64'(groups), 64'd0);
      chk("t1_busy_idle", 64'(busy), 64'd0);

      push(0, 0, 0);
      push(2, 300, 0);
      push(3, 625, 1);
      idle(2);
      setph(0, 0); setph(2, 300); setph(3, 625);
      strobe_expect(4'b1101, 3);
      drain("t2_drain");

      period = 12'd1000;
      push(2, 1500, 0);
      push(2, 1200, 1);
      idle(2);
      setph(2, 999);
      strobe_expect(4'b0100, 2);
      drain("t3_clamp_drain");

      push(1, 100, 0);
      push(1, 200, 1);
      idle(2);
      setph(1, 200);
      strobe_expect(4'b0010, 2);
      drain("t3_dup_drain");

      push(0, 1000, 0);
      push(3, 999, 1);
      idle(2);
      setph(0, 999); setph(3, 999);
      strobe_expect(4'b1001, 2);
      drain("t3_edge_drain");

      push(0, 10, 0); push(1, 20, 0); push(2, 30, 0); push(3, 40, 0);
      push(0, 11, 0); push(1, 21, 0); push(2, 31, 0); push(3, 41, 1);
      chk("t4_ready_full", 64'(cmd_if.cmd_ready), 64'd0);
      idle(1);
      setph(0, 11); setph(1, 21); setph(2, 31); setph(3, 41);
      strobe_expect(4'b1111, 8);
      idle(2);
      pulse();
      drain("t4_drain");
      chk("t4_err_late", 64'(err_late), 64'd1);
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      chk("t4_err_late_clr", 64'(err_late), 64'd0);

      push(0, 1, 0);
      push(1, 2, 0);
      push(2, 3, 1);
      idle(2);
      pulse();
      chk("t5_busy_apply", 64'(busy), 64'd1);
      rst = 1'b1;
      #1;
      cur = '0;
      chk("t5_phase_out", 64'(phase_out), 64'd0);
      chk("t5_phase_upd", 64'(phase_upd), 64'd0);
      chk("t5_busy", 64'(busy), 64'd0);
      chk("t5_groups", 64'(groups), 64'd0);
      chk("t5_ready", 64'(cmd_if.cmd_ready), 64'd1);
      @(negedge clk);
      rst = 1'b0;
      idle(2);
      pulse();
      idle(10);
      chk("t5_busy_after", 64'(busy), 64'd0);

`ifdef PWM_SCHED_HOLDOFF_EN
      holdoff = 8'd2;
      push(0, 5, 1);
      push(1, 6, 1);
      chk("t6_groups_2", 64'(groups), 64'd2);
      idle(2);
      setph(0, 5);
      strobe_expect(4'b0001, 1);
      drain("t6_g1_drain");
      chk("t6_busy_hold", 64'(busy), 64'd1);
      idle(3);
      pulse();
      idle(3);
      chk("t6_busy_hold2", 64'(busy), 64'd1);
      pulse();
      idle(3);
      setph(1, 6);
      strobe_expect(4'b0010, 1);
      drain("t6_g2_drain");
      chk("t6_err_late", 64'(err_late), 64'd0);
      holdoff = 8'd0;
      idle(2);
`endif

      for (int i = 0; i < 8; i++) push(i % 4, i * 10, 0);
      chk("t7_ready_low", 64'(cmd_if.cmd_ready), 64'd0);
      chk("t7_groups_0", 64'(groups), 64'd0);
      cmd_if.cmd_valid = 1'b1;
      @(negedge clk);
      cmd_if.cmd_valid = 1'b0;
      chk("t7_err_ovf", 64'(err_ovf), 64'd1);
      idle(2);
      pulse();
      idle(5);
      chk("t7_busy_idle", 64'(busy), 64'd0);
      cmd_if.cmd_valid = 1'b1;
      clr_err = 1'b1;
      @(negedge clk);
      cmd_if.cmd_valid = 1'b0;
      clr_err = 1'b0;
      chk("t7_clr_priority", 64'(err_ovf), 64'd0);
      idle(2);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
